dg_encode_arbiter: RTL and testbench

//  Shares one 8b->11b Hamming parity encoder between NUM_REQ data-generator requesters.
//  - Round-robin arbitration picks one requester per cycle; its byte is encoded.
//  - The 11b codeword plus source ID go into a 2-entry output FIFO feeding the router injection port.
//  - Synchronous front-end for the async NoC's data-generator path (valid/ready in place of CSP Send/Receive).

---
 rtl/dg_enc_pkg.sv | 30 +++
 rtl/dg_encode_arbiter_rr_arbiter.sv | 43 ++++
 rtl/dg_encode_arbiter.sv | 90 +++++++++
 tb/tb_dg_encode_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dg_enc_pkg.sv
// Shared widths, FIFO entry type and the 8b->11b Hamming parity encoder.
package dg_enc_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CODE_W = 11;
    localparam int unsigned SRC_W  = 4;

    typedef logic [CODE_W-1:0] code_t;

    typedef struct packed {
        code_t            code;
        logic [SRC_W-1:0] src;
    } enc_entry_t;

    // Data occupies c[3:0], c6, c8, c9, c10; parity sits at c4, c5, c7.
    function automatic code_t hamming_encode(input logic [DATA_W-1:0] d);
        code_t c;
        c      = '0;
        c[3:0] = d[3:0];
        c[6]   = d[4];
        c[8]   = d[5];
        c[9]   = d[6];
        c[10]  = d[7];
        c[4]   = c[6] ^ c[8] ^ c[10];
        c[5]   = c[6] ^ c[9] ^ c[10];
        c[7]   = c[8] ^ c[9] ^ c[10];
        return c;
    endfunction

endpackage

// File: rtl/dg_encode_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans from the slot after the last winner; pointer
// moves only when the caller signals that the grant was taken.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] rr_last;

    always_comb begin
        logic        found;
        int unsigned j;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            j = (32'(rr_last) + k) % N;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

    // Reset to the last slot so requester 0 wins first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last <= IW'(N - 1);
        end else if (advance) begin
            rr_last <= grant_idx;
        end
    end

endmodule

// File: rtl/dg_encode_arbiter.sv
// Shares one Hamming encoder between NUM_REQ requesters and buffers the
// {codeword, source} results in a 2-entry FIFO for the router injection port.
module dg_encode_arbiter
    import dg_enc_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [CODE_W-1:0]         out_code,
    output logic [ID_W-1:0]           out_src,
    input  logic                      out_ready,
    output logic [1:0]                fifo_cnt
);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               space;
    logic               push;
    logic               pop;
    logic [1:0]         cnt_nxt;
    logic [DATA_W-1:0]  grant_byte;
    enc_entry_t         new_entry;
    enc_entry_t         mem [2];
    logic               wr_ptr;
    logic               rd_ptr;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req_valid),
        .advance   (push),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Space comes from the registered count only: no pop-through when full.
    always_comb begin
        space          = (fifo_cnt != 2'd2);
        req_ready      = space ? grant : '0;
        push           = |req_ready;
        pop            = out_valid & out_ready;
        grant_byte     = req_data[32'(grant_idx)*DATA_W +: DATA_W];
        new_entry.code = hamming_encode(grant_byte);
        new_entry.src  = SRC_W'(grant_idx);
        unique case ({push, pop})
            2'b10:   cnt_nxt = fifo_cnt + 2'd1;
            2'b01:   cnt_nxt = fifo_cnt - 2'd1;
            default: cnt_nxt = fifo_cnt;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_cnt  <= 2'd0;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt  <= cnt_nxt;
            out_valid <= (cnt_nxt != 2'd0);
        end
    end

    assign out_code = mem[rd_ptr].code;
    assign out_src  = ID_W'(mem[rd_ptr].src);

    a_cnt_range: assert property (@(posedge clk) disable iff (!reset_n)
        fifo_cnt != 2'd3);
    a_ready_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(req_ready));
    a_out_stable: assert property (@(posedge clk) disable iff (!reset_n)
        out_valid && !out_ready |=> out_valid && $stable(out_code) && $stable(out_src));

endmodule

// File: tb/tb_dg_encode_arbiter.sv
// Bench for dg_encode_arbiter: encode table, round-robin order, full-FIFO
// corners, mid-stream reset and a random valid/ready run with a scoreboard.
module tb_dg_encode_arbiter;

    localparam int unsigned N = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N-1:0]     req_valid;
    logic [N*8-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             out_valid;
    logic [10:0]      out_code;
    logic [1:0]       out_src;
    logic             out_ready;
    logic [1:0]       fifo_cnt;

    dg_encode_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_code  (out_code),
        .out_src   (out_src),
        .out_ready (out_ready),
        .fifo_cnt  (fifo_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] code;
        int          src;
    } sb_t;

    typedef struct {
        logic [7:0]  d;
        logic [10:0] c;
    } vec_t;

    sb_t  q[$];
    vec_t vecs[5];
    int   total = 0;
    int   bad = 0;
    int   mcnt;
    int   mrr;
    int   last_gi;
    int   waits[N];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Parity positions expressed as masks over the data byte.
    function automatic logic [10:0] ref_enc(input logic [7:0] d);
        logic p4, p5, p7;
        p4 = ^(d & 8'hB0);
        p5 = ^(d & 8'hD0);
        p7 = ^(d & 8'hE0);
        return {d[7], d[6], d[5], p7, d[4], p5, p4, d[3:0]};
    endfunction

    task automatic set_data(input int i, input logic [7:0] v);
        req_data[i*8 +: 8] = v;
    endtask

    task automatic model_reset();
        q.delete();
        mcnt    = 0;
        mrr     = N - 1;
        last_gi = -1;
        for (int i = 0; i < N; i++) waits[i] = 0;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // One cycle: check against the model, score pops/pushes, advance the clock.
    task automatic tick();
        int  gi;
        int  j;
        bit  pop;
        sb_t e;
        logic [7:0] d;
        #1;
        gi = -1;
        if (mcnt < 2) begin
            for (int k = 1; k <= N; k++) begin
                j = (mrr + k) % N;
                if (gi < 0 && req_valid[j]) gi = j;
            end
        end
        chk("req_ready", int'(req_ready), (gi >= 0) ? (1 << gi) : 0);
        chk("fifo_cnt", int'(fifo_cnt), mcnt);
        chk("out_valid", int'(out_valid), (mcnt != 0) ? 1 : 0);
        pop = (mcnt != 0) && out_ready;
        if (pop) begin
            if (q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = q.pop_front();
                chk("out_code", int'(out_code), int'(e.code));
                chk("out_src", int'(out_src), e.src);
            end
        end
        if (gi >= 0) begin
            d = req_data[gi*8 +: 8];
            q.push_back('{code: ref_enc(d), src: gi});
            for (int i = 0; i < N; i++) begin
                if (i == gi || !req_valid[i]) begin
                    waits[i] = 0;
                end else begin
                    waits[i]++;
                    chk("starve_wait", (waits[i] <= N - 1) ? 1 : 0, 1);
                end
            end
            mrr = gi;
        end
        mcnt    = mcnt + ((gi >= 0) ? 1 : 0) - (pop ? 1 : 0);
        last_gi = gi;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{d: 8'h00, c: 11'h000};
        vecs[1] = '{d: 8'hFF, c: 11'h7FF};
        vecs[2] = '{d: 8'h10, c: 11'h070};
        vecs[3] = '{d: 8'h80, c: 11'h4B0};
        vecs[4] = '{d: 8'h20, c: 11'h190};

        req_data  = '0;
        req_valid = '0;
        out_ready = 1'b0;
        reset_n   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_fifo_cnt", int'(fifo_cnt), 0);
        chk("rst_out_code", int'(out_code), 0);
        chk("rst_out_src", int'(out_src), 0);
        reset_n = 1'b1;

        // Encode table: single requester, entry visible exactly one cycle later.
        out_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            req_valid = 4'b0001;
            set_data(0, vecs[v].d);
            tick();
            req_valid = '0;
            #1;
            chk("enc_valid", int'(out_valid), 1);
            chk("enc_code", int'(out_code), int'(vecs[v].c));
            chk("enc_src", int'(out_src), 0);
            tick();
        end
        tick();

        // All requesters valid: grants rotate 0,1,2,3,0,...
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) set_data(i, 8'(8'h11 * (i + 1)));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_order", int'(req_ready), 1 << (k % N));
            tick();
        end
        req_valid = '0;
        repeat (3) tick();

        // Fill with out_ready low, then pop-only at full, then deferred push.
        do_reset();
        set_data(0, 8'h5A);
        set_data(1, 8'hC3);
        set_data(2, 8'h96);
        req_valid = 4'b0011;
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0100;
        #1;
        chk("full_cnt", int'(fifo_cnt), 2);
        chk("full_ready", int'(req_ready), 0);
        tick();
        out_ready = 1'b1;
        tick();
        #1;
        chk("pop_only_cnt", int'(fifo_cnt), 1);
        chk("deferred_ready", int'(req_ready), 4'b0100);
        tick();
        req_valid = '0;
        repeat (3) tick();

        // Mid-stream reset with a full FIFO.
        do_reset();
        req_valid = 4'b0011;
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        #1;
        chk("pre_rst_cnt", int'(fifo_cnt), 2);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_cnt", int'(fifo_cnt), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("post_rst_grant", int'(req_ready), 4'b0001);
        repeat (4) tick();
        req_valid = '0;
        repeat (3) tick();

        // Random valid/ready; requesters hold valid/data until accepted.
        for (int c = 0; c < 10000; c++) begin
            if (last_gi >= 0) req_valid[last_gi] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
                    req_valid[i] = 1'b1;
                    set_data(i, 8'($urandom_range(255, 0)));
                end
            end
            out_ready = ($urandom_range(3, 0) != 0);
            tick();
        end
        req_valid = '0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("sb_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
